// File: rtl/sqrt_reconstruct.sv
// Rebuilds the radicand D = Q*Q + R from a square-root result (root Q, remainder R).
// It squares Q MSB-first, one root bit per cycle, then adds R. It also flags illegal remainders and overflow.
module sqrt_reconstruct #(
  parameter int QW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [QW-1:0]   Q,
  input  logic [QW:0]     R,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*QW-1:0] D,
  output logic            r_ok,
  output logic            overflow
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t          r_state;
  logic [QW-1:0]   r_q;
  logic [QW:0]     r_r;
  logic [2*QW:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_rOkCap;
  logic            r_inReady;
  logic            r_outValid;
  logic [2*QW-1:0] r_d;
  logic            r_rOk;
  logic            r_overflow;

  logic            w_rOk;
  logic [2*QW:0]   w_partial;
  logic [2*QW:0]   w_sum;

  // A legal remainder never exceeds 2Q, so the widened Q serves as the limit.
  assign w_rOk     = (R <= {Q, 1'b0});
  assign w_partial = r_q[r_cnt] ? {{(QW+1){1'b0}}, r_q} : '0;
  assign w_sum     = r_acc + {{QW{1'b0}}, r_r};

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign D         = r_d;
  assign r_ok      = r_rOk;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_q        <= '0;
      r_r        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rOkCap   <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_d        <= '0;
      r_rOk      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q       <= Q;
            r_r       <= R;
            r_rOkCap  <= w_rOk;
            r_acc     <= '0;
            r_cnt     <= CW'(QW-1);
            r_inReady <= 1'b0;
            r_state   <= MUL;
          end
        end
        MUL: begin
          r_acc <= {r_acc[2*QW-1:0], 1'b0} + w_partial;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= ADD;
          end
        end
        ADD: begin
          // The sum keeps its top bit, so overflow is visible instead of wrapping silently.
          r_acc      <= w_sum;
          r_d        <= w_sum[2*QW-1:0];
          r_overflow <= w_sum[2*QW];
          r_rOk      <= r_rOkCap;
          r_outValid <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Testbench for sqrt_reconstruct. A scoreboard queue holds the expected D/r_ok/overflow and the accept cycle.
// Directed, backpressure, mid-operation reset and sqrt round-trip cases are covered.
module tb_sqrt_reconstruct;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Q;
  logic [16:0] R;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        r_ok;
  logic        overflow;

  typedef struct {
    logic [31:0] d;
    logic        ok;
    logic        ov;
    int          acceptCycle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   validCycle = 0;
  logic prevValid = 1'b0;

  sqrt_reconstruct #(.QW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Q         (Q),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .r_ok      (r_ok),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference root by bit-wise trial squaring; the remainder is whatever is left over.
  function automatic logic [15:0] isqrt(input logic [31:0] d);
    logic [15:0] q;
    logic [15:0] t;
    logic [63:0] tt;
    q = '0;
    for (int b = 15; b >= 0; b--) begin
      t  = q | (16'd1 << b);
      tt = 64'(t) * 64'(t);
      if (tt <= 64'(d)) q = t;
    end
    return q;
  endfunction

  task automatic applyStimulus(input logic [15:0] q, input logic [16:0] r, input logic [31:0] expD,
                               input logic expOk, input logic expOv, input bit push);
    exp_t e;
    int   n;
    n = 0;
    Q = q;
    R = r;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick(1);
    in_valid = 1'b0;
    Q = 16'($urandom);
    R = 17'($urandom);
    if (push) begin
      e.d = expD;
      e.ok = expOk;
      e.ov = expOv;
      e.acceptCycle = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) validCycle = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_D", 64'(D), 64'(e.d));
          checkOutput("out_r_ok", 64'(r_ok), 64'(e.ok));
          checkOutput("out_overflow", 64'(overflow), 64'(e.ov));
          checkOutput("out_latency", 64'(validCycle - e.acceptCycle), 64'd17);
        end
      end
      prevValid = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [15:0] q;
    logic [63:0] rr;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Q = '0;
    R = '0;
    tick(2);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_D", 64'(D), 64'd0);
    checkOutput("rst_r_ok", 64'(r_ok), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] directed cases, issued back to back");
    applyStimulus(16'd0,     17'd0,      32'd0,          1'b1, 1'b0, 1'b1);
    applyStimulus(16'd200,   17'd0,      32'd40000,      1'b1, 1'b0, 1'b1);
    applyStimulus(16'd12,    17'd25,     32'd169,        1'b0, 1'b0, 1'b1);
    applyStimulus(16'd15,    17'd30,     32'd255,        1'b1, 1'b0, 1'b1);
    applyStimulus(16'd65535, 17'd131070, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b1);
    applyStimulus(16'd65535, 17'd131071, 32'd0,          1'b0, 1'b1, 1'b1);
    applyStimulus(16'd0,     17'd5,      32'd5,          1'b0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] backpressure and busy-time in_valid");
    out_ready = 1'b0;
    applyStimulus(16'd16, 17'd0, 32'd256, 1'b1, 1'b0, 1'b1);
    tick(3);
    Q = 16'd3;
    R = 17'd0;
    in_valid = 1'b1;
    tick(2);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        tick(1);
        n++;
      end
      checkOutput("bp_valid_seen", 64'(out_valid), 64'd1);
    end
    Q = 16'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_D_stable", 64'(D), 64'd256);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    tick(3);
    checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_idle_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] reset in the middle of MUL");
    applyStimulus(16'd1000, 17'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(7);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_D", 64'(D), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(20);
    checkOutput("mid_rst_no_emit", 64'(out_valid), 64'd0);
    applyStimulus(16'd1000, 17'd5, 32'd1000005, 1'b1, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] sqrt round trip");
    for (int i = 0; i < 12; i++) begin
      d = (i == 0) ? 32'hFFFFFFFF : ((i == 1) ? 32'd1 : $urandom);
      q = isqrt(d);
      rr = 64'(d) - 64'(q) * 64'(q);
      applyStimulus(q, 17'(rr), d, 1'b1, 1'b0, 1'b1);
      waitDrain();
    end

    tick(2);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
